// File: rtl/virtio_pkg.sv
// Shared types and legacy virtio layout constants for the queue-notify path.
package virtio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_EMIT
    } arb_state_e;

    localparam int PAGE_SHIFT             = 12;
    localparam int DESC_SIZE              = 16;
    localparam int AVAIL_IDX_OFF          = 2;
    localparam logic [7:0] QUEUE_NOTIFY_OFF = 8'h10;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/virtio_rr_pick.sv
// Combinational round-robin picker: first set bit searched upward from ptr+1, wrapping at NUM_Q.
module virtio_rr_pick
    import virtio_pkg::*;
#(
    parameter int NUM_Q = 3,
    parameter int IDX_W = idx_w(NUM_Q)
) (
    input  logic [NUM_Q-1:0] pending,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = 1; i <= NUM_Q; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_Q) begin
                cand = cand - NUM_Q;
            end
            if (!found && pending[IDX_W'(cand)]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/virtio_notify_arb.sv
// Turns queue-notify pulses into (qid, head, count) work items by fetching each
// queue's avail.idx from host memory, one outstanding read at a time.
module virtio_notify_arb
    import virtio_pkg::*;
#(
    parameter int NUM_Q  = 3,
    parameter int QSIZE  = 256,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                drv_ok,
    input  logic                notify_valid,
    input  logic [15:0]         notify_qid,
    input  logic [NUM_Q*32-1:0] q_pfn,
    output logic                rd_req_valid,
    input  logic                rd_req_ready,
    output logic [ADDR_W-1:0]   rd_req_addr,
    input  logic                rd_rsp_valid,
    input  logic [15:0]         rd_rsp_data,
    output logic                work_valid,
    input  logic                work_ready,
    output logic [15:0]         work_qid,
    output logic [15:0]         work_head,
    output logic [15:0]         work_count,
    output logic                err_bad_qid
);

    localparam int IDX_W = idx_w(NUM_Q);
    localparam logic [ADDR_W-1:0] IDX_OFF = ADDR_W'(DESC_SIZE * QSIZE + AVAIL_IDX_OFF);

    arb_state_e        state_q, state_d;
    logic [NUM_Q-1:0]  pending_q, pending_d;
    logic [15:0]       last_idx_q [NUM_Q];
    logic [15:0]       last_idx_d [NUM_Q];
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  cur_q, cur_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       head_q, head_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       new_idx_q, new_idx_d;
    logic              abort_q, abort_d;
    logic              err_q, err_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [31:0]       pick_pfn;
    logic [15:0]       cur_last;
    logic [15:0]       rsp_delta;
    logic              notify_ok;

    virtio_rr_pick #(
        .NUM_Q (NUM_Q),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending (pending_q),
        .ptr     (grant_q),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    always_comb begin
        pick_pfn = '0;
        cur_last = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            if (pick_idx == IDX_W'(q)) begin
                pick_pfn = q_pfn[32*q +: 32];
            end
            if (cur_q == IDX_W'(q)) begin
                cur_last = last_idx_q[q];
            end
        end
    end

    assign rsp_delta = rd_rsp_data - cur_last;
    assign notify_ok = notify_valid && drv_ok;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        last_idx_d = last_idx_q;
        grant_d    = grant_q;
        cur_d      = cur_q;
        addr_d     = addr_q;
        head_d     = head_q;
        count_d    = count_q;
        new_idx_d  = new_idx_q;
        abort_d    = abort_q;
        err_d      = err_q | (notify_ok && (notify_qid >= 16'(NUM_Q)));

        case (state_q)
            ST_IDLE: begin
                if (drv_ok && pick_found) begin
                    state_d = ST_REQ;
                    cur_d   = pick_idx;
                    grant_d = pick_idx;
                    addr_d  = (ADDR_W'(pick_pfn) << PAGE_SHIFT) + IDX_OFF;
                    abort_d = 1'b0;
                    for (int q = 0; q < NUM_Q; q++) begin
                        if (pick_idx == IDX_W'(q)) begin
                            pending_d[q] = 1'b0;
                        end
                    end
                end
            end
            ST_REQ: begin
                // A driver reset cannot retract a presented request; remember to drop its data.
                if (!drv_ok) begin
                    abort_d = 1'b1;
                end
                if (rd_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!drv_ok) begin
                    abort_d = 1'b1;
                end
                if (rd_rsp_valid) begin
                    if (abort_q || !drv_ok) begin
                        state_d = ST_IDLE;
                    end else begin
                        head_d    = cur_last;
                        count_d   = rsp_delta;
                        new_idx_d = rd_rsp_data;
                        state_d   = (rsp_delta == 16'd0) ? ST_IDLE : ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (!drv_ok) begin
                    state_d = ST_IDLE;
                end else if (work_ready) begin
                    for (int q = 0; q < NUM_Q; q++) begin
                        if (cur_q == IDX_W'(q)) begin
                            last_idx_d[q] = new_idx_q;
                        end
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Applied after the grant clear so a same-cycle notify re-arms the queue.
        for (int q = 0; q < NUM_Q; q++) begin
            if (notify_ok && (notify_qid == 16'(q))) begin
                pending_d[q] = 1'b1;
            end
        end

        if (!drv_ok) begin
            pending_d = '0;
            for (int q = 0; q < NUM_Q; q++) begin
                last_idx_d[q] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            last_idx_q <= '{default: '0};
            grant_q    <= IDX_W'(NUM_Q - 1);
            cur_q      <= '0;
            addr_q     <= '0;
            head_q     <= '0;
            count_q    <= '0;
            new_idx_q  <= '0;
            abort_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            last_idx_q <= last_idx_d;
            grant_q    <= grant_d;
            cur_q      <= cur_d;
            addr_q     <= addr_d;
            head_q     <= head_d;
            count_q    <= count_d;
            new_idx_q  <= new_idx_d;
            abort_q    <= abort_d;
            err_q      <= err_d;
        end
    end

    assign rd_req_valid = (state_q == ST_REQ);
    assign rd_req_addr  = addr_q;
    assign work_valid   = (state_q == ST_EMIT) && drv_ok;
    assign work_qid     = 16'(cur_q);
    assign work_head    = head_q;
    assign work_count   = count_q;
    assign err_bad_qid  = err_q;

endmodule

// File: tb/tb_virtio_notify_arb.sv
// Bench for virtio_notify_arb: directed scenarios plus randomized notify batches
// checked against a transaction-level queue model.
module tb_virtio_notify_arb;

    localparam int NUM_Q  = 3;
    localparam int QSIZE  = 256;
    localparam int ADDR_W = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic                drv_ok;
    logic                notify_valid;
    logic [15:0]         notify_qid;
    logic [NUM_Q*32-1:0] q_pfn;
    logic                rd_req_valid;
    logic                rd_req_ready;
    logic [ADDR_W-1:0]   rd_req_addr;
    logic                rd_rsp_valid;
    logic [15:0]         rd_rsp_data;
    logic                work_valid;
    logic                work_ready;
    logic [15:0]         work_qid;
    logic [15:0]         work_head;
    logic [15:0]         work_count;
    logic                err_bad_qid;

    logic [31:0] pfn [NUM_Q];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign q_pfn = {pfn[2], pfn[1], pfn[0]};

    virtio_notify_arb #(.NUM_Q(NUM_Q), .QSIZE(QSIZE), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .drv_ok(drv_ok),
        .notify_valid(notify_valid), .notify_qid(notify_qid), .q_pfn(q_pfn),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .work_valid(work_valid), .work_ready(work_ready), .work_qid(work_qid),
        .work_head(work_head), .work_count(work_count), .err_bad_qid(err_bad_qid)
    );

    // Legacy layout: ring base is PFN * 4 KiB; avail.idx follows the descriptor table.
    function automatic logic [63:0] exp_addr(input int q);
        return 64'(pfn[q]) * 64'd4096 + 64'(16 * QSIZE) + 64'd2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0; drv_ok = 1'b1; notify_valid = 1'b0; notify_qid = '0;
        rd_req_ready = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_data = '0; work_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic notify(input int qid);
        notify_valid = 1'b1; notify_qid = 16'(qid);
        tick();
        notify_valid = 1'b0;
    endtask

    task automatic accept_req();
        rd_req_ready = 1'b1; tick(); rd_req_ready = 1'b0;
    endtask

    task automatic send_rsp(input logic [15:0] data);
        rd_rsp_valid = 1'b1; rd_rsp_data = data; tick(); rd_rsp_valid = 1'b0;
    endtask

    task automatic accept_work();
        work_ready = 1'b1; tick(); work_ready = 1'b0;
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rd_req_valid) begin seen = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_work(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (work_valid) begin seen = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; drv_ok = 1'b0; notify_valid = 1'b0; notify_qid = '0;
        rd_req_ready = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_data = '0; work_ready = 1'b0;
        #3;
        checks++; if ({rd_req_valid, work_valid, err_bad_qid} !== 3'b000) begin errors++; $display("FAIL reset_valids: got %b expected 000", {rd_req_valid, work_valid, err_bad_qid}); end
        checks++; if ({rd_req_addr, work_qid, work_head, work_count} !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", {rd_req_addr, work_qid, work_head, work_count}); end
        reset_dut();
        repeat (5) tick();
        checks++; if (rd_req_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b expected 0", rd_req_valid); end
    endtask

    task automatic test_basic();
        bit seen;
        reset_dut();
        notify_valid = 1'b1; notify_qid = 16'd1;
        tick();
        notify_valid = 1'b0;
        checks++; if (rd_req_valid !== 1'b0) begin errors++; $display("FAIL basic_lat_n1: got %b expected 0", rd_req_valid); end
        tick();
        checks++; if (rd_req_valid !== 1'b1) begin errors++; $display("FAIL basic_lat_n2: got %b expected 1", rd_req_valid); end
        checks++; if (rd_req_addr !== 64'h13002) begin errors++; $display("FAIL basic_addr: got %h expected %h", rd_req_addr, 64'h13002); end
        accept_req();
        send_rsp(16'h0003);
        wait_work(seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL basic_work1_seen: got %b expected 1", seen); end
        checks++; if ({work_qid, work_head, work_count} !== {16'd1, 16'd0, 16'd3}) begin errors++; $display("FAIL basic_work1: got %h expected %h", {work_qid, work_head, work_count}, {16'd1, 16'd0, 16'd3}); end
        accept_work();
        checks++; if (work_valid !== 1'b0) begin errors++; $display("FAIL basic_work1_drop: got %b expected 0", work_valid); end
        notify(1);
        wait_req(seen);
        accept_req();
        send_rsp(16'h0005);
        wait_work(seen);
        checks++; if ({work_qid, work_head, work_count} !== {16'd1, 16'd3, 16'd2}) begin errors++; $display("FAIL basic_work2: got %h expected %h", {work_qid, work_head, work_count}, {16'd1, 16'd3, 16'd2}); end
        accept_work();
    endtask

    task automatic test_round_robin();
        bit seen;
        int exp_order [4] = '{0, 1, 2, 0};
        logic [15:0] last [NUM_Q] = '{default: '0};
        reset_dut();
        notify(2);
        wait_req(seen);
        checks++; if (rd_req_addr !== exp_addr(2)) begin errors++; $display("FAIL rr_first_addr: got %h expected %h", rd_req_addr, exp_addr(2)); end
        notify(1); notify(0); notify(2);
        accept_req();
        send_rsp(16'd1);
        last[2] = 16'd1;
        wait_work(seen);
        accept_work();
        for (int k = 0; k < 4; k++) begin
            int q = exp_order[k];
            wait_req(seen);
            checks++; if (rd_req_addr !== exp_addr(q)) begin errors++; $display("FAIL rr_addr_%0d: got %h expected %h", k, rd_req_addr, exp_addr(q)); end
            if (k == 0) notify(0);
            accept_req();
            send_rsp(last[q] + 16'd1);
            wait_work(seen);
            checks++; if ({work_qid, work_head, work_count} !== {16'(q), last[q], 16'd1}) begin errors++; $display("FAIL rr_work_%0d: got %h expected %h", k, {work_qid, work_head, work_count}, {16'(q), last[q], 16'd1}); end
            last[q] = last[q] + 16'd1;
            accept_work();
        end
        wait_req(seen);
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rr_no_extra: got %b expected 0", seen); end
    endtask

    task automatic test_wrap();
        bit seen;
        reset_dut();
        notify(2); wait_req(seen); accept_req(); send_rsp(16'hFFFE); wait_work(seen);
        checks++; if ({work_head, work_count} !== {16'h0000, 16'hFFFE}) begin errors++; $display("FAIL wrap_first: got %h expected %h", {work_head, work_count}, {16'h0000, 16'hFFFE}); end
        accept_work();
        notify(2); wait_req(seen); accept_req(); send_rsp(16'h0001); wait_work(seen);
        checks++; if ({work_qid, work_head, work_count} !== {16'd2, 16'hFFFE, 16'd3}) begin errors++; $display("FAIL wrap_count: got %h expected %h", {work_qid, work_head, work_count}, {16'd2, 16'hFFFE, 16'd3}); end
        accept_work();
    endtask

    task automatic test_zero_count();
        bit seen;
        bit any;
        reset_dut();
        notify(0); wait_req(seen); accept_req(); send_rsp(16'd4); wait_work(seen); accept_work();
        notify(0); wait_req(seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL zero_req_seen: got %b expected 1", seen); end
        accept_req();
        send_rsp(16'd4);
        any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (work_valid || rd_req_valid) any = 1'b1;
            tick();
        end
        checks++; if (any !== 1'b0) begin errors++; $display("FAIL zero_no_activity: got %b expected 0", any); end
    endtask

    task automatic test_bad_qid();
        bit seen;
        reset_dut();
        checks++; if (err_bad_qid !== 1'b0) begin errors++; $display("FAIL bad_pre: got %b expected 0", err_bad_qid); end
        notify(5);
        checks++; if (err_bad_qid !== 1'b1) begin errors++; $display("FAIL bad_set: got %b expected 1", err_bad_qid); end
        wait_req(seen);
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL bad_no_req: got %b expected 0", seen); end
        notify(0); wait_req(seen); accept_req(); send_rsp(16'd1); wait_work(seen); accept_work();
        checks++; if (err_bad_qid !== 1'b1) begin errors++; $display("FAIL bad_sticky: got %b expected 1", err_bad_qid); end
    endtask

    task automatic test_drv_ok();
        bit seen;
        reset_dut();
        notify(1); wait_req(seen); accept_req(); send_rsp(16'd7); wait_work(seen); accept_work();
        // Drop in WAIT: response is eaten, last_idx forgotten.
        notify(1); wait_req(seen); accept_req();
        drv_ok = 1'b0;
        tick();
        send_rsp(16'd9);
        checks++; if ({work_valid, rd_req_valid} !== 2'b00) begin errors++; $display("FAIL drv_wait_discard: got %b expected 00", {work_valid, rd_req_valid}); end
        notify(0);
        drv_ok = 1'b1;
        wait_req(seen);
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL drv_notify_ignored: got %b expected 0", seen); end
        notify(1); wait_req(seen); accept_req(); send_rsp(16'd4); wait_work(seen);
        checks++; if ({work_head, work_count} !== {16'd0, 16'd4}) begin errors++; $display("FAIL drv_last_cleared: got %h expected %h", {work_head, work_count}, {16'd0, 16'd4}); end
        accept_work();
        // Drop in REQ: request persists until accepted, then nothing is emitted.
        notify(0); wait_req(seen);
        drv_ok = 1'b0;
        tick();
        checks++; if (rd_req_valid !== 1'b1) begin errors++; $display("FAIL drv_req_hold: got %b expected 1", rd_req_valid); end
        accept_req(); send_rsp(16'd3);
        drv_ok = 1'b1;
        repeat (3) tick();
        checks++; if ({work_valid, rd_req_valid} !== 2'b00) begin errors++; $display("FAIL drv_req_discard: got %b expected 00", {work_valid, rd_req_valid}); end
        // Drop in EMIT: work_valid falls in the same cycle.
        notify(2); wait_req(seen); accept_req(); send_rsp(16'd5);
        checks++; if (work_valid !== 1'b1) begin errors++; $display("FAIL drv_emit_pre: got %b expected 1", work_valid); end
        drv_ok = 1'b0;
        #1;
        checks++; if (work_valid !== 1'b0) begin errors++; $display("FAIL drv_emit_drop: got %b expected 0", work_valid); end
        tick();
        drv_ok = 1'b1;
        tick();
        checks++; if ({work_valid, rd_req_valid} !== 2'b00) begin errors++; $display("FAIL drv_emit_idle: got %b expected 00", {work_valid, rd_req_valid}); end
    endtask

    task automatic test_stall();
        bit seen;
        reset_dut();
        notify(0); wait_req(seen); accept_req(); send_rsp(16'd2);
        for (int i = 0; i < 10; i++) begin
            checks++; if ({work_valid, work_qid, work_head, work_count} !== {1'b1, 16'd0, 16'd0, 16'd2}) begin errors++; $display("FAIL stall_hold_%0d: got %h expected %h", i, {work_valid, work_qid, work_head, work_count}, {1'b1, 16'd0, 16'd0, 16'd2}); end
            if (i == 4) notify(0);
            else tick();
        end
        accept_work();
        wait_req(seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL stall_refetch: got %b expected 1", seen); end
        accept_req(); send_rsp(16'd6); wait_work(seen);
        checks++; if ({work_head, work_count} !== {16'd2, 16'd4}) begin errors++; $display("FAIL stall_second: got %h expected %h", {work_head, work_count}, {16'd2, 16'd4}); end
        accept_work();
    endtask

    task automatic test_async_reset();
        bit seen;
        reset_dut();
        notify(1); wait_req(seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL areset_req: got %b expected 1", seen); end
        #3;
        rst = 1'b0;
        #1;
        checks++; if ({rd_req_valid, work_valid, err_bad_qid} !== 3'b000) begin errors++; $display("FAIL areset_valids: got %b expected 000", {rd_req_valid, work_valid, err_bad_qid}); end
        checks++; if ({rd_req_addr, work_qid, work_head, work_count} !== '0) begin errors++; $display("FAIL areset_data: got %h expected 0", {rd_req_addr, work_qid, work_head, work_count}); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_random();
        bit seen;
        bit err_exp;
        bit pend [NUM_Q];
        logic [15:0] last [NUM_Q];
        int ptr;
        for (int q = 0; q < NUM_Q; q++) begin pfn[q] = $urandom; last[q] = '0; end
        reset_dut();
        ptr = NUM_Q - 1;
        err_exp = 1'b0;
        for (int b = 0; b < 8; b++) begin
            int order [$];
            int first = -1;
            int n = $urandom_range(1, 6);
            for (int q = 0; q < NUM_Q; q++) pend[q] = 1'b0;
            for (int k = 0; k < n; k++) begin
                int qid = ($urandom_range(0, 4) == 0) ? $urandom_range(NUM_Q, NUM_Q + 6) : $urandom_range(0, NUM_Q - 1);
                notify(qid);
                if (qid >= NUM_Q) err_exp = 1'b1;
                else if (first < 0) first = qid;
                else pend[qid] = 1'b1;
            end
            if (first >= 0) begin
                order.push_back(first);
                ptr = first;
            end
            for (int s = 0; s < NUM_Q; s++) begin
                for (int i = 1; i <= NUM_Q; i++) begin
                    int c = (ptr + i) % NUM_Q;
                    if (pend[c]) begin order.push_back(c); pend[c] = 1'b0; ptr = c; break; end
                end
            end
            foreach (order[j]) begin
                int q = order[j];
                logic [15:0] delta;
                wait_req(seen);
                checks++; if (seen !== 1'b1 || rd_req_addr !== exp_addr(q)) begin errors++; $display("FAIL rand_req_b%0d_%0d: got %b/%h expected 1/%h", b, j, seen, rd_req_addr, exp_addr(q)); end
                repeat ($urandom_range(0, 2)) tick();
                accept_req();
                repeat ($urandom_range(0, 2)) tick();
                delta = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
                send_rsp(last[q] + delta);
                if (delta == 16'd0) begin
                    checks++; if (work_valid !== 1'b0) begin errors++; $display("FAIL rand_nowork_b%0d_%0d: got %b expected 0", b, j, work_valid); end
                end else begin
                    wait_work(seen);
                    checks++; if ({seen, work_qid, work_head, work_count} !== {1'b1, 16'(q), last[q], delta}) begin errors++; $display("FAIL rand_work_b%0d_%0d: got %h expected %h", b, j, {seen, work_qid, work_head, work_count}, {1'b1, 16'(q), last[q], delta}); end
                    repeat ($urandom_range(0, 3)) tick();
                    accept_work();
                    last[q] = last[q] + delta;
                end
            end
            repeat (4) tick();
            checks++; if ({rd_req_valid, err_bad_qid} !== {1'b0, err_exp}) begin errors++; $display("FAIL rand_end_b%0d: got %b expected %b", b, {rd_req_valid, err_bad_qid}, {1'b0, err_exp}); end
        end
    endtask

    initial begin
        pfn[0] = 32'h100; pfn[1] = 32'h12; pfn[2] = 32'h300;
        test_reset();
        test_basic();
        test_round_robin();
        test_wrap();
        test_zero_count();
        test_bad_qid();
        test_drv_ok();
        test_stall();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
